// File: rtl/gpu_pkg.sv
// Shared types and constants for the triangle rasterizer.
// Vertex component indices and edge accumulator sizing live here.
package gpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP_A,
        SETUP_B,
        SCAN,
        DONE
    } raster_state_t;

    localparam int VX = 0;
    localparam int VY = 1;
    localparam int VZ = 2;

    function automatic int edge_width(input int cw);
        return 2 * cw + 4;
    endfunction

endpackage

// File: rtl/edge_eval.sv
// One incremental edge function: holds deltas, running E and row-start E.
// E_ab(p) = dx*(py-ya) - dy*(px-xa), stepped by -dy in x and +dx in y.
module edge_eval import gpu_pkg::*; #(
    parameter int CW = 16,
    parameter int EW = edge_width(CW)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          setup,
    input  logic          step_x,
    input  logic          step_y,
    input  logic [CW-1:0] xa,
    input  logic [CW-1:0] ya,
    input  logic [CW-1:0] xb,
    input  logic [CW-1:0] yb,
    input  logic [CW-1:0] px,
    input  logic [CW-1:0] py,
    output logic [EW-1:0] e
);

    logic signed [CW:0]   dx_q, dx_d;
    logic signed [CW:0]   dy_q, dy_d;
    logic signed [EW-1:0] e_q, e_d;
    logic signed [EW-1:0] row_q, row_d;
    logic signed [EW-1:0] rel_x, rel_y;

    assign rel_x = EW'($signed(px)) - EW'($signed(xa));
    assign rel_y = EW'($signed(py)) - EW'($signed(ya));

    always_comb begin
        dx_d  = dx_q;
        dy_d  = dy_q;
        e_d   = e_q;
        row_d = row_q;
        if (load) begin
            dx_d = {xb[CW-1], xb} - {xa[CW-1], xa};
            dy_d = {yb[CW-1], yb} - {ya[CW-1], ya};
        end else if (setup) begin
            e_d   = EW'(dx_q) * rel_y - EW'(dy_q) * rel_x;
            row_d = e_d;
        end else if (step_y) begin
            e_d   = row_q + EW'(dx_q);
            row_d = e_d;
        end else if (step_x) begin
            e_d = e_q - EW'(dy_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dx_q  <= '0;
            dy_q  <= '0;
            e_q   <= '0;
            row_q <= '0;
        end else begin
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            e_q   <= e_d;
            row_q <= row_d;
        end
    end

    assign e = e_q;

endmodule

// File: rtl/triangle_raster.sv
// Flat-shaded bounding-box scan rasterizer with a valid/ready pixel stream.
// Walks the screen-clamped box row-major, one box pixel per unstalled cycle.
module triangle_raster import gpu_pkg::*; #(
    parameter int COORD_WIDTH = 16,
    parameter int COLOR_WIDTH = 16,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int EDGE_WIDTH  = edge_width(COORD_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [COORD_WIDTH-1:0] vertexes [3][3],
    input  logic [COLOR_WIDTH-1:0] colors,
    output logic                   busy,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [COORD_WIDTH-1:0] pix_x,
    output logic [COORD_WIDTH-1:0] pix_y,
    output logic [COLOR_WIDTH-1:0] pix_color,
    output logic                   done
);

    localparam int CW = COORD_WIDTH;
    localparam int EW = EDGE_WIDTH;
    localparam logic signed [CW-1:0] ZERO  = '0;
    localparam logic signed [CW-1:0] X_LIM = CW'(SCREEN_W - 1);
    localparam logic signed [CW-1:0] Y_LIM = CW'(SCREEN_H - 1);

    raster_state_t state_q, state_d;
    logic signed [CW-1:0] vx_q [3];
    logic signed [CW-1:0] vx_d [3];
    logic signed [CW-1:0] vy_q [3];
    logic signed [CW-1:0] vy_d [3];
    logic [COLOR_WIDTH-1:0] col_q, col_d;
    logic signed [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic signed [CW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic signed [CW-1:0] x_q, x_d, y_q, y_d;
    logic empty_q, empty_d;

    logic signed [CW-1:0] lo_x, hi_x, lo_y, hi_y;
    logic signed [EW-1:0] area;
    logic [EW-1:0] e [3];
    logic load_e, setup_e, step_x, step_y;
    logic all_pos, all_neg, covered, advance;
    logic unused_z;

    assign unused_z = ^{vertexes[0][VZ], vertexes[1][VZ], vertexes[2][VZ]};

    // Clamped bounding box from the captured vertices.
    always_comb begin
        lo_x = vx_q[0];
        hi_x = vx_q[0];
        lo_y = vy_q[0];
        hi_y = vy_q[0];
        for (int i = 1; i < 3; i++) begin
            if (vx_q[i] < lo_x) lo_x = vx_q[i];
            if (vx_q[i] > hi_x) hi_x = vx_q[i];
            if (vy_q[i] < lo_y) lo_y = vy_q[i];
            if (vy_q[i] > hi_y) hi_y = vy_q[i];
        end
        if (lo_x < ZERO)  lo_x = ZERO;
        if (hi_x > X_LIM) hi_x = X_LIM;
        if (lo_y < ZERO)  lo_y = ZERO;
        if (hi_y > Y_LIM) hi_y = Y_LIM;
    end

    assign area = (EW'(vx_q[1]) - EW'(vx_q[0])) * (EW'(vy_q[2]) - EW'(vy_q[0]))
                - (EW'(vy_q[1]) - EW'(vy_q[0])) * (EW'(vx_q[2]) - EW'(vx_q[0]));

    for (genvar i = 0; i < 3; i++) begin : g_edge
        localparam int B = (i + 1) % 3;
        edge_eval #(.CW(CW), .EW(EW)) u_edge (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load_e),
            .setup   (setup_e),
            .step_x  (step_x),
            .step_y  (step_y),
            .xa      (vx_q[i]),
            .ya      (vy_q[i]),
            .xb      (vx_q[B]),
            .yb      (vy_q[B]),
            .px      (xmin_q),
            .py      (ymin_q),
            .e       (e[i])
        );
    end

    // Either winding counts as inside; zero sits on both sides.
    always_comb begin
        all_pos = 1'b1;
        all_neg = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (e[i][EW-1]) all_pos = 1'b0;
            if (!e[i][EW-1] && e[i] != '0) all_neg = 1'b0;
        end
        covered = all_pos || all_neg;
    end

    assign advance = !covered || pix_ready;

    always_comb begin
        state_d = state_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        col_d   = col_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        empty_d = empty_q;
        x_d     = x_q;
        y_d     = y_q;
        load_e  = 1'b0;
        setup_e = 1'b0;
        step_x  = 1'b0;
        step_y  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 3; i++) begin
                        vx_d[i] = vertexes[i][VX];
                        vy_d[i] = vertexes[i][VY];
                    end
                    col_d   = colors;
                    state_d = SETUP_A;
                end
            end
            SETUP_A: begin
                load_e  = 1'b1;
                xmin_d  = lo_x;
                xmax_d  = hi_x;
                ymin_d  = lo_y;
                ymax_d  = hi_y;
                empty_d = (lo_x > hi_x) || (lo_y > hi_y);
                state_d = SETUP_B;
            end
            SETUP_B: begin
                setup_e = 1'b1;
                x_d     = xmin_q;
                y_d     = ymin_q;
                state_d = (area == '0 || empty_q) ? DONE : SCAN;
            end
            SCAN: begin
                if (advance) begin
                    if (x_q != xmax_q) begin
                        step_x = 1'b1;
                        x_d    = x_q + CW'(1);
                    end else if (y_q != ymax_q) begin
                        step_y = 1'b1;
                        x_d    = xmin_q;
                        y_d    = y_q + CW'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            vx_q    <= '{default: '0};
            vy_q    <= '{default: '0};
            col_q   <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            empty_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            col_q   <= col_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            empty_q <= empty_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign pix_valid = (state_q == SCAN) && covered;
    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign pix_color = col_q;

endmodule

// File: tb/tb_triangle_raster.sv
// Scoreboard bench for triangle_raster: directed triangles, queued pixels.
// A negedge monitor pops and compares every transferred pixel.
module tb_triangle_raster;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] vertexes [3][3];
    logic [15:0] colors;
    logic        busy;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic [15:0] pix_color;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int mode = 0;
    logic [47:0] exp_q [$];

    triangle_raster dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .vertexes  (vertexes),
        .colors    (colors),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, req, req);
        end
    endtask

    // Ready driver: 0 always ready, 1 random, 2 never ready.
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: pix_ready = 1'b1;
                1: pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = 1'b0;
            endcase
        end
    end

    // Monitor
    initial begin
        logic        prev_stall;
        logic [47:0] prev_word;
        logic [47:0] want;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (prev_stall) begin
                    chk("stall_valid_held", pix_valid, 1);
                    chk("stall_outputs_held", {pix_x, pix_y, pix_color}, prev_word);
                end
                if (pix_valid && pix_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pixel", {pix_x, pix_y}, 0);
                    end else begin
                        want = exp_q.pop_front();
                        chk("pix_x", pix_x, want[47:32]);
                        chk("pix_y", pix_y, want[31:16]);
                        chk("pix_color", pix_color, want[15:0]);
                    end
                end
                prev_stall = pix_valid && !pix_ready;
                prev_word  = {pix_x, pix_y, pix_color};
            end
        end
    end

    task automatic set_v(input int x0, y0, x1, y1, x2, y2);
        vertexes[0][VX] = 16'(x0);
        vertexes[0][VY] = 16'(y0);
        vertexes[1][VX] = 16'(x1);
        vertexes[1][VY] = 16'(y1);
        vertexes[2][VX] = 16'(x2);
        vertexes[2][VY] = 16'(y2);
        for (int i = 0; i < 3; i++) vertexes[i][VZ] = 16'(i * 7);
    endtask

    task automatic launch(input int x0, y0, x1, y1, x2, y2, input logic [15:0] col);
        @(posedge clk);
        #1;
        set_v(x0, y0, x1, y1, x2, y2);
        colors = col;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        set_v(111, 222, 333, 44, 55, 66);
        colors = 16'hDEAD;
    endtask

    // Counts cycles from the start cycle (0); call right after launch.
    task automatic wait_done(output int cyc, output int fv);
        int d0;
        d0 = done_cnt;
        cyc = -1;
        fv = -1;
        for (int c = 1; c < 3000; c++) begin
            @(negedge clk);
            if (pix_valid && fv < 0) fv = c;
            if (done) begin
                cyc = c;
                break;
            end
            @(posedge clk);
        end
        if (cyc < 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            @(posedge clk);
            @(negedge clk);
            chk("busy_after_done", busy, 0);
            chk("done_single_pulse", done_cnt - d0, 1);
        end
        chk("all_pixels_seen", exp_q.size(), 0);
    endtask

    task automatic push_small(input logic [15:0] col);
        for (int y = 0; y <= 3; y++)
            for (int x = 0; x <= 3; x++)
                if (x + y <= 3) exp_q.push_back({16'(x), 16'(y), col});
    endtask

    int cyc, fv;

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        colors = '0;
        set_v(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_xy", {pix_x, pix_y}, 0);
        chk("rst_color", pix_color, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        mode = 0;
        push_small(16'h1234);
        launch(0, 0, 3, 0, 0, 3, 16'h1234);
        wait_done(cyc, fv);
        chk("t1_first_valid_cycle", fv, 3);
        chk("t1_done_cycle", cyc, 19);

        mode = 1;
        push_small(16'h00A5);
        launch(0, 0, 3, 0, 0, 3, 16'h00A5);
        wait_done(cyc, fv);

        mode = 0;
        push_small(16'h5A5A);
        launch(0, 0, 0, 3, 3, 0, 16'h5A5A);
        wait_done(cyc, fv);
        chk("t3_done_cycle", cyc, 19);

        launch(0, 0, 2, 2, 4, 4, 16'h0001);
        wait_done(cyc, fv);
        chk("collinear_done_cycle", cyc, 3);
        chk("collinear_no_valid", fv, -1);

        launch(-10, -10, -5, -10, -10, -5, 16'h0002);
        wait_done(cyc, fv);
        chk("offscreen_done_cycle", cyc, 3);
        chk("offscreen_no_valid", fv, -1);

        for (int y = 470; y <= 479; y++)
            for (int x = 630; x <= 639; x++)
                exp_q.push_back({16'(x), 16'(y), 16'hBEEF});
        launch(630, 470, 660, 470, 630, 500, 16'hBEEF);
        wait_done(cyc, fv);
        chk("clip_first_valid_cycle", fv, 3);
        chk("clip_done_cycle", cyc, 103);

        push_small(16'h0F0F);
        launch(0, 0, 3, 0, 0, 3, 16'h0F0F);
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                set_v(0, 0, 5, 0, 0, 5);
                colors = 16'hFFFF;
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join_none
        wait_done(cyc, fv);
        chk("start_in_scan_done_cycle", cyc, 19);

        mode = 2;
        push_small(16'h7777);
        launch(0, 0, 3, 0, 0, 3, 16'h7777);
        fv = -1;
        for (int c = 0; c < 20 && fv < 0; c++) begin
            @(negedge clk);
            if (pix_valid) fv = c;
        end
        chk("stall_reached_valid", fv >= 0, 1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midreset_valid", pix_valid, 0);
        chk("midreset_busy", busy, 0);
        exp_q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        mode = 0;
        push_small(16'h4321);
        launch(0, 0, 3, 0, 0, 3, 16'h4321);
        wait_done(cyc, fv);
        chk("after_reset_first_valid", fv, 3);
        chk("after_reset_done_cycle", cyc, 19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/triangle_raster.md
# triangle_raster

Flat-shaded scan rasterizer sitting directly downstream of `data_fetch`.
- On `start` it captures the three fetched vertices and the triangle colour.
- It computes a screen-clamped bounding box and three edge functions, then walks the box row-major.
- It emits one pixel per cycle for every covered pixel over a valid/ready stream to the pixel writer.
- It pulses `done` when the triangle is finished.

## Interface
Parameters:
- COORD_WIDTH, 16, vertex coordinate width, signed two's complement
- COLOR_WIDTH, 16, colour width
- SCREEN_W, 640, horizontal resolution in pixels
- SCREEN_H, 480, vertical resolution in pixels
- EDGE_WIDTH, 2*COORD_WIDTH+4, signed edge-function accumulator width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  accept a triangle; sampled only in IDLE
- vertexes  in  [COORD_WIDTH-1:0] [3][3]  vertex i, component j; j=0 x, j=1 y, j=2 z (z ignored)
- colors  in  COLOR_WIDTH  flat triangle colour
- busy  out  1  high in every state except IDLE
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  downstream accepts pixel
- pix_x  out  COORD_WIDTH  pixel x, unsigned, < SCREEN_W
- pix_y  out  COORD_WIDTH  pixel y, unsigned, < SCREEN_H
- pix_color  out  COLOR_WIDTH  captured colour
- done  out  1  one-cycle pulse at end of triangle

## Operation
- **States:**
  - IDLE -> SETUP_A on `start`.
  - SETUP_A -> SETUP_B.
  - SETUP_B -> SCAN, or -> DONE if area = 0 or the clamped box is empty.
  - SCAN -> DONE after the last box pixel is resolved.
  - DONE -> IDLE.
- **IDLE, on `start`:** register x/y of all three vertices and `colors`. Inputs may change afterwards.
- **SETUP_A:**
  - Deltas dx_ab = xb-xa and dy_ab = yb-ya, for edges ab = (0,1), (1,2), (2,0). Deltas are COORD_WIDTH+1 bits, sign-extended.
  - Bounding box min/max of x and y, clamped to [0, SCREEN_W-1] × [0, SCREEN_H-1].
  - The box is empty if max < 0, min > SCREEN-1, or min > max after clamping.
- **SETUP_B:**
  - Edge value at (xmin, ymin): E_ab = dx_ab·(py-ya) - dy_ab·(px-xa), at EDGE_WIDTH bits.
  - Triangle area = E_01 evaluated at vertex 2.
- **SCAN:**
  - Current pixel is covered iff all three E >= 0 or all three E <= 0. Both windings are accepted.
  - Edge pixels are inclusive; there is no top-left rule, so shared edges are drawn twice.
  - Step x+1: E -= dy. End of row: x = xmin, y+1, E = row_start + dx, and row_start is updated.
  - Uncovered pixels are skipped with no output cycle.
  - A covered pixel sets pix_valid. The scan holds, with outputs stable, until `pix_ready`.
- **Walk order:** row-major, x ascending within a row, y ascending.
- **DONE:** `done` = 1 for exactly one cycle.
- `start` outside IDLE is ignored.

## Timing
- **Reset values:** state IDLE; busy, pix_valid and done 0; pix_x, pix_y and pix_color 0.
- Reset asserted mid-operation drops pix_valid immediately and discards the triangle.
- **Latency:** with `start` sampled at cycle 0, SETUP_A is cycle 1 and SETUP_B is cycle 2.
  - The first box pixel is evaluated at cycle 3, so pix_valid can rise earliest at cycle 3.
  - For a degenerate or empty triangle, done = 1 at cycle 3.
- **Throughput:** one box pixel resolved per cycle while not stalled.
- **Handshake:**
  - A pixel transfers on pix_valid && pix_ready.
  - pix_valid never drops without a transfer.
  - pix_ready may be high while pix_valid is low.
- done rises in the cycle after the last pixel transfers or is skipped; busy falls one cycle after done.

## Structure
- **Package `gpu_pkg`:**
  - typedef raster_state_t {IDLE, SETUP_A, SETUP_B, SCAN, DONE}
  - constants VX = 0, VY = 1, VZ = 2
  - EDGE_WIDTH derivation
- **Sub-module `edge_eval`:** one edge.
  - Holds the deltas, current E and row_start E.
  - Has setup, step_x and step_y controls.
  - Instantiated 3 times.

## Test plan
1. Vertices (0,0),(3,0),(0,3), colour 0x1234, pix_ready=1 -> exactly 10 pixels, all with x+y <= 3, order (0,0),(1,0),(2,0),(3,0),(0,1)…(0,3), colour 0x1234; first pix_valid at cycle 3; one done pulse.
2. Same triangle with random pix_ready -> identical 10-pixel sequence; pix_x, pix_y and pix_color stable during every stall; no duplicate or dropped pixels.
3. Opposite winding (0,0),(0,3),(3,0) -> same 10 pixels in the same order.
4. Collinear (0,0),(2,2),(4,4) -> no pix_valid, done at cycle 3. Fully off-screen (-10,-10),(-5,-10),(-10,-5) -> no pixels, done at cycle 3.
5. Partly off-screen (630,470),(660,470),(630,500) with 640×480 -> every pixel has x <= 639 and y <= 479; first pixel (630,470).
6. `start` pulsed during SCAN -> ignored, current triangle completes unchanged. reset_n low mid-SCAN -> pix_valid = 0 at once, state IDLE; a new `start` then rasterizes correctly.
